// File: rtl/j1_boot_ctrl.sv
// rtl/j1_boot_ctrl.sv - j1 boot sequencer and code-RAM port arbiter
//
// Loads a program image from a byte stream into code RAM and holds the j1
// core in reset until the image checksum verifies. Then it releases the core
// to fetch from address 0.
//
// Image format: MAGIC, count_hi, count_lo, {lo, hi} x count, xor_checksum
//
// Ports:
//   clk           system clock, rising edge
//   resetq        asynchronous active-low reset
//   rx_data       incoming byte
//   rx_valid      rx_data valid
//   rx_ready      byte accepted on a clk edge when rx_valid & rx_ready
//   cpu_resetq    j1 reset (active low), registered
//   j1_code_addr  j1 fetch address
//   ram_addr      code RAM address: load index while core held, else fetch address
//   ram_we        code RAM write strobe, registered
//   ram_wdata     code RAM write data, registered
//   busy          load in progress
//   done          sticky, last load passed
//   err           sticky, last load failed

module j1_boot_ctrl #(
    parameter int         DEPTH     = 8192,
    parameter bit         BOOT_HOLD = 1'b1,
    parameter int         TIMEOUT   = 1000000,
    parameter logic [7:0] MAGIC     = 8'hA5
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        cpu_resetq,
    input  logic [12:0] j1_code_addr,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [15:0] ram_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int              TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
    localparam logic [16:0]     DEPTH_W    = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_RUN,
        S_HOLD,
        S_CNT_HI,
        S_CNT_LO,
        S_DAT_LO,
        S_DAT_HI,
        S_CSUM,
        S_RELEASE
    } state_t;

    state_t          r_state;
    logic            r_cpu_resetq;
    logic            r_ram_we;
    logic [15:0]     r_ram_wdata;
    logic            r_done;
    logic            r_err;
    logic [15:0]     r_index;
    logic [15:0]     r_count;
    logic [7:0]      r_cnt_hi;
    logic [7:0]      r_lo;
    logic [7:0]      r_csum;
    logic [TW-1:0]   r_timer;

    logic            w_accept;
    logic            w_loading;
    logic [15:0]     w_count;
    logic [15:0]     w_index_next;

    assign rx_ready     = (r_state != S_RELEASE);
    assign w_accept     = rx_valid & rx_ready;
    assign w_loading    = (r_state == S_CNT_HI) || (r_state == S_CNT_LO) ||
                          (r_state == S_DAT_LO) || (r_state == S_DAT_HI) ||
                          (r_state == S_CSUM);
    assign w_count      = {r_cnt_hi, rx_data};
    assign w_index_next = r_index + 16'd1;

    assign busy       = w_loading | (r_state == S_RELEASE);
    assign cpu_resetq = r_cpu_resetq;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;
    assign done       = r_done;
    assign err        = r_err;

    // The index is only advanced the cycle after the write strobe, so the
    // address presented with ram_we is the index of the word being written.
    assign ram_addr = r_cpu_resetq ? j1_code_addr : r_index[12:0];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state      <= BOOT_HOLD ? S_HOLD : S_RUN;
            r_cpu_resetq <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= 16'd0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_index      <= 16'd0;
            r_count      <= 16'd0;
            r_cnt_hi     <= 8'd0;
            r_lo         <= 8'd0;
            r_csum       <= 8'd0;
            r_timer      <= '0;
        end else begin
            r_ram_we <= 1'b0;
            if (r_ram_we) begin
                r_index <= w_index_next;
            end

            case (r_state)
                S_RUN, S_HOLD: begin
                    if (r_state == S_RUN) begin
                        r_cpu_resetq <= 1'b1;
                    end
                    if (w_accept && (rx_data == MAGIC)) begin
                        r_state      <= S_CNT_HI;
                        r_cpu_resetq <= 1'b0;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_csum       <= 8'd0;
                        r_index      <= 16'd0;
                        r_timer      <= '0;
                    end
                end
                S_CNT_HI: begin
                    if (w_accept) begin
                        r_cnt_hi <= rx_data;
                        r_state  <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (w_accept) begin
                        r_count <= w_count;
                        if ({1'b0, w_count} > DEPTH_W) begin
                            r_err   <= 1'b1;
                            r_state <= S_HOLD;
                        end else if (w_count == 16'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DAT_LO;
                        end
                    end
                end
                S_DAT_LO: begin
                    if (w_accept) begin
                        r_lo    <= rx_data;
                        r_csum  <= r_csum ^ rx_data;
                        r_state <= S_DAT_HI;
                    end
                end
                S_DAT_HI: begin
                    if (w_accept) begin
                        r_ram_we    <= 1'b1;
                        r_ram_wdata <= {rx_data, r_lo};
                        r_csum      <= r_csum ^ rx_data;
                        r_state     <= (w_index_next == r_count) ? S_CSUM : S_DAT_LO;
                    end
                end
                S_CSUM: begin
                    if (w_accept) begin
                        if (rx_data == r_csum) begin
                            r_done  <= 1'b1;
                            r_state <= S_RELEASE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_RELEASE: begin
                    r_cpu_resetq <= 1'b1;
                    r_state      <= S_RUN;
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase

            // Inter-byte watchdog; an accepted byte always wins over expiry.
            if (w_loading) begin
                if (w_accept) begin
                    r_timer <= '0;
                end else if (r_timer == TIMER_LAST) begin
                    r_timer <= '0;
                    r_err   <= 1'b1;
                    r_state <= S_HOLD;
                end else begin
                    r_timer <= r_timer + TIMER_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_j1_boot_ctrl.sv
// tb/tb_j1_boot_ctrl.sv - self-checking bench for j1_boot_ctrl
module tb_j1_boot_ctrl;

    localparam int R_TIMEOUT = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // held-boot instance
    logic        h_resetq, h_rx_valid, h_rx_ready, h_cpu_resetq, h_ram_we, h_busy, h_done, h_err;
    logic [7:0]  h_rx_data;
    logic [12:0] h_j1_addr, h_ram_addr;
    logic [15:0] h_ram_wdata;

    // run-from-reset instance
    logic        r_resetq, r_rx_valid, r_rx_ready, r_cpu_resetq, r_ram_we, r_busy, r_done, r_err;
    logic [7:0]  r_rx_data;
    logic [12:0] r_j1_addr, r_ram_addr;
    logic [15:0] r_ram_wdata;

    j1_boot_ctrl #(.DEPTH(8192), .BOOT_HOLD(1'b1), .TIMEOUT(1000000), .MAGIC(8'hA5)) dut_h (
        .clk(clk), .resetq(h_resetq), .rx_data(h_rx_data), .rx_valid(h_rx_valid),
        .rx_ready(h_rx_ready), .cpu_resetq(h_cpu_resetq), .j1_code_addr(h_j1_addr),
        .ram_addr(h_ram_addr), .ram_we(h_ram_we), .ram_wdata(h_ram_wdata),
        .busy(h_busy), .done(h_done), .err(h_err)
    );

    j1_boot_ctrl #(.DEPTH(8192), .BOOT_HOLD(1'b0), .TIMEOUT(R_TIMEOUT), .MAGIC(8'hA5)) dut_r (
        .clk(clk), .resetq(r_resetq), .rx_data(r_rx_data), .rx_valid(r_rx_valid),
        .rx_ready(r_rx_ready), .cpu_resetq(r_cpu_resetq), .j1_code_addr(r_j1_addr),
        .ram_addr(r_ram_addr), .ram_we(r_ram_we), .ram_wdata(r_ram_wdata),
        .busy(r_busy), .done(r_done), .err(r_err)
    );

    // Scoreboard of expected {addr, data} writes, and observed strobe counts.
    logic [28:0] h_q[$];
    logic [28:0] r_q[$];
    int h_exp_we = 0;
    int r_exp_we = 0;
    int h_we_cnt = 0;
    int r_we_cnt = 0;

    always @(negedge clk) begin
        if (h_ram_we === 1'b1) h_we_cnt <= h_we_cnt + 1;
        if (r_ram_we === 1'b1) r_we_cnt <= r_we_cnt + 1;
    end

    // All sends start and end 1 time unit after a rising edge.
    task automatic send_h(input logic [7:0] b);
        int n;
        h_rx_data  = b;
        h_rx_valid = 1'b1;
        n = 0;
        while (h_rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (h_rx_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL h_rx_ready_wait rx_ready=%b expected 1", h_rx_ready);
        end
        @(posedge clk); #1;
        h_rx_valid = 1'b0;
    endtask

    task automatic send_r(input logic [7:0] b);
        int n;
        r_rx_data  = b;
        r_rx_valid = 1'b1;
        n = 0;
        while (r_rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (r_rx_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL r_rx_ready_wait rx_ready=%b expected 1", r_rx_ready);
        end
        @(posedge clk); #1;
        r_rx_valid = 1'b0;
    endtask

    task automatic h_word(input logic [12:0] a, input logic [15:0] d);
        logic [28:0] e;
        h_q.push_back({a, d});
        h_exp_we++;
        send_h(d[7:0]);
        send_h(d[15:8]);
        e = h_q.pop_front();
        checks++;
        if (h_ram_we !== 1'b1 || {h_ram_addr, h_ram_wdata} !== e) begin
            failures++;
            $display("FAIL h_ram_write we=%b addr=%h data=%h expected addr=%h data=%h",
                     h_ram_we, h_ram_addr, h_ram_wdata, e[28:16], e[15:0]);
        end
    endtask

    task automatic check_h_writes(input string name);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (h_we_cnt !== h_exp_we || h_q.size() != 0) begin
            failures++;
            $display("FAIL %s we_count=%0d expected %0d pending=%0d", name, h_we_cnt, h_exp_we, h_q.size());
        end
    endtask

    task automatic test_reset();
        h_resetq = 1'b0; r_resetq = 1'b0;
        h_rx_valid = 1'b0; r_rx_valid = 1'b0;
        h_rx_data = 8'h00; r_rx_data = 8'h00;
        h_j1_addr = 13'h1F00; r_j1_addr = 13'h0123;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({h_cpu_resetq, h_ram_we, h_ram_wdata, h_done, h_err, h_busy, h_rx_ready} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_h cpu_resetq=%b we=%b wdata=%h done=%b err=%b busy=%b rdy=%b expected 0 0 0000 0 0 0 1",
                     h_cpu_resetq, h_ram_we, h_ram_wdata, h_done, h_err, h_busy, h_rx_ready);
        end
        checks++;
        if (h_ram_addr !== 13'h0) begin
            failures++;
            $display("FAIL reset_h_addr ram_addr=%h expected 0000", h_ram_addr);
        end
        h_resetq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (h_cpu_resetq !== 1'b0 || h_busy !== 1'b0) begin
            failures++;
            $display("FAIL hold_after_reset cpu_resetq=%b busy=%b expected 0 0", h_cpu_resetq, h_busy);
        end
    endtask

    task automatic test_good_load();
        logic [7:0] cs;
        cs = 8'h34 ^ 8'h12 ^ 8'h78 ^ 8'h56;
        send_h(8'hA5);
        checks++;
        if (h_busy !== 1'b1) begin
            failures++;
            $display("FAIL good_busy busy=%b expected 1", h_busy);
        end
        send_h(8'h00);
        send_h(8'h02);
        h_word(13'd0, 16'h1234);
        h_word(13'd1, 16'h5678);
        send_h(cs);
        checks++;
        if ({h_done, h_err, h_cpu_resetq, h_rx_ready, h_busy} !== 5'b10001) begin
            failures++;
            $display("FAIL good_release done=%b err=%b cpu_resetq=%b rdy=%b busy=%b expected 1 0 0 0 1",
                     h_done, h_err, h_cpu_resetq, h_rx_ready, h_busy);
        end
        @(posedge clk); #1;
        checks++;
        if (h_cpu_resetq !== 1'b1 || h_busy !== 1'b0 || h_rx_ready !== 1'b1) begin
            failures++;
            $display("FAIL good_run cpu_resetq=%b busy=%b rdy=%b expected 1 0 1", h_cpu_resetq, h_busy, h_rx_ready);
        end
        h_j1_addr = 13'h0ABC;
        #1;
        checks++;
        if (h_ram_addr !== 13'h0ABC) begin
            failures++;
            $display("FAIL fetch_mux ram_addr=%h expected 0abc", h_ram_addr);
        end
        check_h_writes("good_write_count");
    endtask

    task automatic test_bad_checksum_recover();
        logic [7:0] cs;
        cs = 8'h34 ^ 8'h12 ^ 8'h78 ^ 8'h56;
        send_h(8'hA5);
        checks++;
        if (h_cpu_resetq !== 1'b0 || h_done !== 1'b0) begin
            failures++;
            $display("FAIL magic_clears cpu_resetq=%b done=%b expected 0 0", h_cpu_resetq, h_done);
        end
        send_h(8'h00); send_h(8'h02);
        h_word(13'd0, 16'h1234);
        h_word(13'd1, 16'h5678);
        send_h(8'h2F);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({h_err, h_done, h_cpu_resetq, h_busy, h_rx_ready} !== 5'b10001) begin
            failures++;
            $display("FAIL bad_csum err=%b done=%b cpu_resetq=%b busy=%b rdy=%b expected 1 0 0 0 1",
                     h_err, h_done, h_cpu_resetq, h_busy, h_rx_ready);
        end
        send_h(8'hA5); send_h(8'h00); send_h(8'h02);
        h_word(13'd0, 16'h1234);
        h_word(13'd1, 16'h5678);
        send_h(cs);
        @(posedge clk); #1;
        checks++;
        if ({h_done, h_err, h_cpu_resetq} !== 3'b101) begin
            failures++;
            $display("FAIL recover done=%b err=%b cpu_resetq=%b expected 1 0 1", h_done, h_err, h_cpu_resetq);
        end
        check_h_writes("recover_write_count");
    endtask

    task automatic test_count_too_big();
        send_h(8'hA5); send_h(8'h20); send_h(8'h01);
        checks++;
        if ({h_err, h_done, h_busy, h_cpu_resetq} !== 4'b1000) begin
            failures++;
            $display("FAIL count_overflow err=%b done=%b busy=%b cpu_resetq=%b expected 1 0 0 0",
                     h_err, h_done, h_busy, h_cpu_resetq);
        end
        check_h_writes("overflow_no_write");
    endtask

    task automatic test_zero_count();
        send_h(8'hA5); send_h(8'h00); send_h(8'h00);
        send_h(8'h00);
        checks++;
        if (h_done !== 1'b1 || h_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_done done=%b err=%b expected 1 0", h_done, h_err);
        end
        @(posedge clk); #1;
        checks++;
        if (h_cpu_resetq !== 1'b1) begin
            failures++;
            $display("FAIL zero_release cpu_resetq=%b expected 1", h_cpu_resetq);
        end
        check_h_writes("zero_no_write");
    endtask

    task automatic test_run_mode_timeout();
        int n;
        logic [28:0] e;
        checks++;
        if (r_cpu_resetq !== 1'b0) begin
            failures++;
            $display("FAIL r_reset cpu_resetq=%b expected 0", r_cpu_resetq);
        end
        r_resetq = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (r_cpu_resetq !== 1'b1) begin
            failures++;
            $display("FAIL r_first_edge cpu_resetq=%b expected 1", r_cpu_resetq);
        end
        r_j1_addr = 13'h0456;
        send_r(8'h11); send_r(8'h22);
        checks++;
        if ({r_cpu_resetq, r_busy, r_ram_addr} !== {1'b1, 1'b0, 13'h0456}) begin
            failures++;
            $display("FAIL r_ignore cpu_resetq=%b busy=%b ram_addr=%h expected 1 0 0456", r_cpu_resetq, r_busy, r_ram_addr);
        end
        send_r(8'hA5);
        checks++;
        if (r_cpu_resetq !== 1'b0 || r_busy !== 1'b1) begin
            failures++;
            $display("FAIL r_magic_edge cpu_resetq=%b busy=%b expected 0 1", r_cpu_resetq, r_busy);
        end
        send_r(8'h00); send_r(8'h02);
        r_q.push_back({13'd0, 16'hBEEF});
        r_exp_we++;
        send_r(8'hEF); send_r(8'hBE);
        e = r_q.pop_front();
        checks++;
        if (r_ram_we !== 1'b1 || {r_ram_addr, r_ram_wdata} !== e) begin
            failures++;
            $display("FAIL r_ram_write we=%b addr=%h data=%h expected addr=%h data=%h",
                     r_ram_we, r_ram_addr, r_ram_wdata, e[28:16], e[15:0]);
        end
        send_r(8'hA5);
        n = 0;
        while (r_err !== 1'b1 && n < R_TIMEOUT + 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n != R_TIMEOUT) begin
            failures++;
            $display("FAIL r_timeout_cycles got=%0d expected %0d", n, R_TIMEOUT);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({r_err, r_done, r_cpu_resetq, r_busy} !== 4'b1000 || r_we_cnt != r_exp_we) begin
            failures++;
            $display("FAIL r_timeout_hold err=%b done=%b cpu_resetq=%b busy=%b we_count=%0d expected 1 0 0 0 %0d",
                     r_err, r_done, r_cpu_resetq, r_busy, r_we_cnt, r_exp_we);
        end
    endtask

    task automatic test_async_reset();
        send_h(8'hA5); send_h(8'h00); send_h(8'h02);
        h_word(13'd0, 16'hCAFE);
        send_h(8'h11);
        h_rx_data  = 8'h22;
        h_rx_valid = 1'b1;
        #2;
        h_resetq = 1'b0;
        #1;
        checks++;
        if ({h_ram_we, h_cpu_resetq, h_done, h_err, h_busy, h_ram_wdata} !== {5'b00000, 16'h0}) begin
            failures++;
            $display("FAIL async_reset we=%b cpu_resetq=%b done=%b err=%b busy=%b wdata=%h expected 0 0 0 0 0 0000",
                     h_ram_we, h_cpu_resetq, h_done, h_err, h_busy, h_ram_wdata);
        end
        @(posedge clk); #1;
        checks++;
        if (h_ram_we !== 1'b0 || h_ram_addr !== 13'h0) begin
            failures++;
            $display("FAIL async_reset_edge we=%b ram_addr=%h expected 0 0000", h_ram_we, h_ram_addr);
        end
        h_rx_valid = 1'b0;
        h_resetq   = 1'b1;
        check_h_writes("async_no_write");
        checks++;
        if (h_cpu_resetq !== 1'b0 || h_busy !== 1'b0) begin
            failures++;
            $display("FAIL async_after cpu_resetq=%b busy=%b expected 0 0", h_cpu_resetq, h_busy);
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_bad_checksum_recover();
        test_count_too_big();
        test_zero_count();
        test_run_mode_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
